// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and output sequencer sharing one valid/ready channel.
// Define MUX_RR_ARBITER_BURST_HOLD_EN to let a winner hold the grant for up to MAX_HOLD beats.
module mux_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  input  logic                      out_ready,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic                      busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("mux_rr_arbiter: unsupported parameters");
  end

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e              state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                busy_q;
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       w_q;

  logic [DATA_W-1:0]   din [NUM_REQ];
  logic [PW-1:0]       win;
  logic [NUM_REQ-1:0]  win_oh;
  logic                found;
  int                  idx;
  logic [PW-1:0]       ptr_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign din[i] = data_in[i*DATA_W +: DATA_W];
  end

  // Scan from ptr upward with wrap; first set request wins.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  assign ptr_d = (w_q == LAST) ? '0 : w_q + PW'(1);

`ifdef MUX_RR_ARBITER_BURST_HOLD_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_q;
  logic          burst_go;

  assign burst_go = req[w_q] && (hold_q < HOLD_LAST);
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      w_q     <= '0;
`ifdef MUX_RR_ARBITER_BURST_HOLD_EN
      hold_q  <= '0;
`endif
    end else begin
      ack_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (found) begin
            gnt_q   <= win_oh;
            data_q  <= din[win];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            w_q     <= win;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            ack_q <= gnt_q;
`ifdef MUX_RR_ARBITER_BURST_HOLD_EN
            if (burst_go) begin
              data_q <= din[w_q];
              hold_q <= hold_q + HW'(1);
            end else begin
              gnt_q   <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              ptr_q   <= ptr_d;
              hold_q  <= '0;
              state_q <= IDLE;
            end
`else
            gnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;

endmodule
